// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the parametrised I2S / left-justified transmitter.
package i2s_pkg;

  localparam int unsigned MODE_I2S = 0;
  localparam int unsigned MODE_LJ  = 1;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock divider, bit counter and falling-event / frame-load strobes.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter  int unsigned SLOT_W    = 32,
  parameter  int unsigned SCLK_HALF = 8,
  localparam int unsigned DIV_W     = cnt_w(SCLK_HALF),
  localparam int unsigned BC_W      = cnt_w(2 * SLOT_W)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            sclk,
  output logic [BC_W-1:0] bc_nxt_c,
  output logic            fall_c,
  output logic            load_c
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(2 * SLOT_W - 1);

  logic [DIV_W-1:0] div;
  logic [BC_W-1:0]  bc;
  logic             wrap_c;

  // Strobes: a falling event is the divider wrap while sclk is high.
  always_comb begin
    wrap_c   = (div == DIV_LAST);
    fall_c   = wrap_c & sclk;
    load_c   = fall_c & (bc == BC_LAST);
    bc_nxt_c = (bc == BC_LAST) ? '0 : bc + BC_W'(1);
  end

  // Divider, bit clock and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      sclk <= 1'b0;
      bc   <= '0;
    end else begin
      div <= wrap_c ? '0 : div + DIV_W'(1);
      if (wrap_c) sclk <= ~sclk;
      if (fall_c) bc <= bc_nxt_c;
    end
  end

endmodule

// File: rtl/i2s_tx_param.sv
// Stereo I2S / left-justified transmitter with a one-frame holding buffer and underrun reporting.
module i2s_tx_param
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = 24,
  parameter int unsigned SLOT_W    = 32,
  parameter int unsigned SCLK_HALF = 8,
  parameter int unsigned MODE      = 0
) (
  input  logic                clk48m,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                mute,
  output logic                sclk,
  output logic                lrclk,
  output logic                dout,
  output logic                frame_start,
  output logic                underrun
);

  localparam int unsigned BC_W    = cnt_w(2 * SLOT_W);
  localparam int unsigned FRAME_W = 2 * SLOT_W;

  logic [BC_W-1:0]     bc_nxt_c;
  logic                fall_c;
  logic                load_c;
  logic                accept_c;
  logic                full;
  logic [SAMPLE_W-1:0] hold_l, hold_r;
  logic [SAMPLE_W-1:0] last_l, last_r;
  logic [SAMPLE_W-1:0] src_l_c, src_r_c;
  logic [FRAME_W-1:0]  shreg;
  logic [FRAME_W-1:0]  frame_c;
  logic [FRAME_W-1:0]  shreg_nxt_c;
  logic                lr_nxt_c;
  logic                dout_nxt_c;

  i2s_clkgen #(
    .SLOT_W    (SLOT_W),
    .SCLK_HALF (SCLK_HALF)
  ) u_clkgen (
    .clk      (clk48m),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .bc_nxt_c (bc_nxt_c),
    .fall_c   (fall_c),
    .load_c   (load_c)
  );

  assign accept_c = sample_valid & sample_ready;

  // Frame source selection (fresh pair, repeat of last pair, or mute) and shift update.
  always_comb begin
    src_l_c = hold_l;
    src_r_c = hold_r;
    if (!full) begin
      src_l_c = last_l;
      src_r_c = last_r;
    end
    frame_c = (FRAME_W'(src_l_c) << (FRAME_W - SAMPLE_W)) |
              (FRAME_W'(src_r_c) << (SLOT_W - SAMPLE_W));
    if (mute) frame_c = '0;
    shreg_nxt_c = shreg;
    if (load_c) begin
      shreg_nxt_c = frame_c;
    end else if (fall_c) begin
      shreg_nxt_c = {shreg[FRAME_W-2:0], 1'b0};
    end
  end

  // Mode mux: LJ shows the new MSB, I2S shows the MSB from one bit earlier.
  always_comb begin
    if (MODE == MODE_LJ) begin
      lr_nxt_c   = (bc_nxt_c >= BC_W'(SLOT_W));
      dout_nxt_c = shreg_nxt_c[FRAME_W-1];
    end else begin
      lr_nxt_c   = (bc_nxt_c >= BC_W'(SLOT_W - 1)) && (bc_nxt_c <= BC_W'(2 * SLOT_W - 2));
      dout_nxt_c = shreg[FRAME_W-1];
    end
  end

  // Holding buffer, last-pair memory and ready handshake.
  always_ff @(posedge clk48m or negedge rst_n) begin
    if (!rst_n) begin
      full         <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      last_l       <= '0;
      last_r       <= '0;
      sample_ready <= 1'b1;
    end else begin
      if (accept_c) begin
        hold_l <= sample_l;
        hold_r <= sample_r;
        full   <= 1'b1;
      end else if (load_c) begin
        full <= 1'b0;
      end
      if (load_c && full) begin
        last_l <= hold_l;
        last_r <= hold_r;
      end
      if (accept_c) begin
        sample_ready <= 1'b0;
      end else if (frame_start && !full) begin
        sample_ready <= 1'b1;
      end
    end
  end

  // Shift register and serial outputs.
  always_ff @(posedge clk48m or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      lrclk       <= 1'b0;
      dout        <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      shreg       <= shreg_nxt_c;
      frame_start <= load_c;
      underrun    <= load_c & ~full & ~mute;
      if (fall_c) begin
        lrclk <= lr_nxt_c;
        dout  <= dout_nxt_c;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_param.sv
// Bench for i2s_tx_param: default LJ and I2S instances plus a small 16/16/2 I2S instance.
module tb_i2s_tx_param;

  logic clk48m;
  logic rst_n;

  logic [23:0] sl, sr;
  logic        sv, mute;
  logic a_ready, a_sclk, a_lrclk, a_dout, a_fs, a_ur;
  logic b_ready, b_sclk, b_lrclk, b_dout, b_fs, b_ur;

  logic [15:0] c_l, c_r;
  logic        c_v, c_mute;
  logic c_ready, c_sclk, c_lrclk, c_dout, c_fs, c_ur;

  int total = 0;
  int bad   = 0;

  bit q_a[$], ql_a[$], q_b[$], ql_b[$], q_c[$], ql_c[$];
  bit b_last = 1'b0;
  bit c_last = 1'b0;
  bit arm_a = 1'b0, arm_b = 1'b0, arm_c = 1'b0;
  logic pa = 1'b0, pb = 1'b0, pc = 1'b0;

  initial clk48m = 1'b0;
  always #5 clk48m = ~clk48m;

  i2s_tx_param #(.SAMPLE_W(24), .SLOT_W(32), .SCLK_HALF(8), .MODE(1)) dut_a (
    .clk48m(clk48m), .rst_n(rst_n), .sample_l(sl), .sample_r(sr), .sample_valid(sv),
    .sample_ready(a_ready), .mute(mute), .sclk(a_sclk), .lrclk(a_lrclk), .dout(a_dout),
    .frame_start(a_fs), .underrun(a_ur));

  i2s_tx_param #(.SAMPLE_W(24), .SLOT_W(32), .SCLK_HALF(8), .MODE(0)) dut_b (
    .clk48m(clk48m), .rst_n(rst_n), .sample_l(sl), .sample_r(sr), .sample_valid(sv),
    .sample_ready(b_ready), .mute(mute), .sclk(b_sclk), .lrclk(b_lrclk), .dout(b_dout),
    .frame_start(b_fs), .underrun(b_ur));

  i2s_tx_param #(.SAMPLE_W(16), .SLOT_W(16), .SCLK_HALF(2), .MODE(0)) dut_c (
    .clk48m(clk48m), .rst_n(rst_n), .sample_l(c_l), .sample_r(c_r), .sample_valid(c_v),
    .sample_ready(c_ready), .mute(c_mute), .sclk(c_sclk), .lrclk(c_lrclk), .dout(c_dout),
    .frame_start(c_fs), .underrun(c_ur));

  // Frame as a bit vector: frame bit k (transmit order) sits at v[63-k].
  function automatic logic [63:0] frame_vec(input logic [31:0] l, input logic [31:0] r,
                                             input int sw, input int slw);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < sw; i++) begin
      v[63-i]       = l[sw-1-i];
      v[63-slw-i]   = r[sw-1-i];
    end
    return v;
  endfunction

  // Expected LJ and I2S streams for one default-geometry frame.
  function automatic void push_ab(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] v;
    v = frame_vec({8'h00, l}, {8'h00, r}, 24, 32);
    for (int k = 0; k < 64; k++) begin
      q_a.push_back(v[63-k]);
      ql_a.push_back(k >= 32);
      q_b.push_back((k == 0) ? b_last : v[64-k]);
      ql_b.push_back((k >= 31) && (k <= 62));
    end
    b_last = v[0];
  endfunction

  // Expected I2S stream for one 16/16 frame.
  function automatic void push_c(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] v;
    v = frame_vec({16'h0000, l}, {16'h0000, r}, 16, 16);
    for (int k = 0; k < 32; k++) begin
      q_c.push_back((k == 0) ? c_last : v[64-k]);
      ql_c.push_back((k >= 15) && (k <= 30));
    end
    c_last = v[32];
  endfunction

  task automatic tick();
    @(negedge clk48m);
  endtask

  // Advance until frame_start of instance a (sel 0) or c (sel 2); counts underruns seen before it.
  task automatic wait_fs(input int sel, input int limit, output bit ok, output int n, output int urs);
    ok = 1'b0; n = 0; urs = 0;
    while (n < limit) begin
      tick();
      n++;
      if ((sel == 0) ? a_fs : c_fs) begin
        ok = 1'b1;
        break;
      end
      if ((sel == 0) ? a_ur : c_ur) urs++;
    end
  endtask

  // Stream scoreboard: pops one expected bit per falling event once a queued frame has started.
  always @(negedge clk48m) begin
    bit e, el;
    if (rst_n) begin
      if (a_fs && q_a.size() > 0) arm_a = 1'b1;
      if (b_fs && q_b.size() > 0) arm_b = 1'b1;
      if (c_fs && q_c.size() > 0) arm_c = 1'b1;
      if (arm_a && pa && !a_sclk) begin
        e = q_a.pop_front(); el = ql_a.pop_front();
        total++;
        if (a_dout !== e || a_lrclk !== el) begin
          bad++;
          $display("FAIL lj_stream got dout=%b lrclk=%b want dout=%b lrclk=%b left=%0d", a_dout, a_lrclk, e, el, q_a.size());
        end
        if (q_a.size() == 0) arm_a = 1'b0;
      end
      if (arm_b && pb && !b_sclk) begin
        e = q_b.pop_front(); el = ql_b.pop_front();
        total++;
        if (b_dout !== e || b_lrclk !== el) begin
          bad++;
          $display("FAIL i2s_stream got dout=%b lrclk=%b want dout=%b lrclk=%b left=%0d", b_dout, b_lrclk, e, el, q_b.size());
        end
        if (q_b.size() == 0) arm_b = 1'b0;
      end
      if (arm_c && pc && !c_sclk) begin
        e = q_c.pop_front(); el = ql_c.pop_front();
        total++;
        if (c_dout !== e || c_lrclk !== el) begin
          bad++;
          $display("FAIL small_stream got dout=%b lrclk=%b want dout=%b lrclk=%b left=%0d", c_dout, c_lrclk, e, el, q_c.size());
        end
        if (q_c.size() == 0) arm_c = 1'b0;
      end
    end
    pa = a_sclk; pb = b_sclk; pc = c_sclk;
  end

  task automatic test_reset();
    rst_n = 1'b0; sv = 1'b0; mute = 1'b0; sl = '0; sr = '0;
    c_v = 1'b0; c_mute = 1'b0; c_l = '0; c_r = '0;
    repeat (3) tick();
    total++;
    if ({a_sclk, a_lrclk, a_dout, a_fs, a_ur, a_ready} !== 6'b000001) begin
      bad++; $display("FAIL reset_a got=%b want=000001", {a_sclk, a_lrclk, a_dout, a_fs, a_ur, a_ready});
    end
    total++;
    if ({b_sclk, b_lrclk, b_dout, b_fs, b_ur, b_ready} !== 6'b000001) begin
      bad++; $display("FAIL reset_b got=%b want=000001", {b_sclk, b_lrclk, b_dout, b_fs, b_ur, b_ready});
    end
    total++;
    if ({c_sclk, c_lrclk, c_dout, c_fs, c_ur, c_ready} !== 6'b000001) begin
      bad++; $display("FAIL reset_c got=%b want=000001", {c_sclk, c_lrclk, c_dout, c_fs, c_ur, c_ready});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_frames();
    bit ok; int n, urs;
    sl = 24'h800001; sr = 24'h7FFFFF; sv = 1'b1;
    tick();
    sv = 1'b0;
    total++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      bad++; $display("FAIL accept_ready got=%b%b want=00", a_ready, b_ready);
    end
    push_ab(24'h800001, 24'h7FFFFF);
    wait_fs(0, 1100, ok, n, urs);
    total++;
    if (!ok || n != 1023) begin
      bad++; $display("FAIL first_load ok=%0d cycles=%0d want cycles=1023", ok, n);
    end
    total++;
    if (a_ur !== 1'b0 || b_ur !== 1'b0 || b_fs !== 1'b1 || a_ready !== 1'b0) begin
      bad++; $display("FAIL load2_flags got ur=%b%b bfs=%b ready=%b want 00 1 0", a_ur, b_ur, b_fs, a_ready);
    end
    tick();
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_fs got=%b%b want=11", a_ready, b_ready);
    end
    push_ab(24'h800001, 24'h7FFFFF);
    wait_fs(0, 1100, ok, n, urs);
    total++;
    if (!ok || n != 1023) begin
      bad++; $display("FAIL frame_period ok=%0d cycles=%0d want cycles=1023", ok, n);
    end
    total++;
    if (a_ur !== 1'b1 || b_ur !== 1'b1 || urs != 0) begin
      bad++; $display("FAIL underrun_pulse got=%b%b early=%0d want=11 early=0", a_ur, b_ur, urs);
    end
    tick();
    total++;
    if (a_ur !== 1'b0) begin
      bad++; $display("FAIL underrun_width got=%b want=0", a_ur);
    end
  endtask

  task automatic test_mute();
    bit ok; int n, urs;
    sl = 24'h123456; sr = 24'h654321; sv = 1'b1;
    tick();
    sv = 1'b0;
    total++;
    if (a_ready !== 1'b0) begin
      bad++; $display("FAIL mute_accept got=%b want=0", a_ready);
    end
    mute = 1'b1;
    push_ab(24'h000000, 24'h000000);
    wait_fs(0, 1100, ok, n, urs);
    total++;
    if (!ok || n != 1022 || a_ur !== 1'b0 || urs != 0 || a_ready !== 1'b0) begin
      bad++; $display("FAIL mute_load ok=%0d cycles=%0d ur=%b early=%0d ready=%b want 1 1022 0 0 0", ok, n, a_ur, urs, a_ready);
    end
    tick();
    mute = 1'b0;
    total++;
    if (a_ready !== 1'b1) begin
      bad++; $display("FAIL mute_ready got=%b want=1", a_ready);
    end
    wait_fs(0, 1100, ok, n, urs);
    total++;
    if (!ok || a_ur !== 1'b1) begin
      bad++; $display("FAIL empty_after_mute ok=%0d ur=%b want 1 1", ok, a_ur);
    end
  endtask

  task automatic test_small();
    bit ok; int n, urs, m, first, per;
    logic p;
    wait_fs(2, 200, ok, n, urs);
    tick(); tick();
    c_l = 16'hA5C3; c_r = 16'h1235; c_v = 1'b1;
    tick();
    c_v = 1'b0;
    total++;
    if (!ok || c_ready !== 1'b0) begin
      bad++; $display("FAIL small_accept ok=%0d ready=%b want 1 0", ok, c_ready);
    end
    push_c(16'hA5C3, 16'h1235);
    wait_fs(2, 200, ok, n, urs);
    total++;
    if (!ok || n != 125 || c_ur !== 1'b0) begin
      bad++; $display("FAIL small_load ok=%0d cycles=%0d ur=%b want 1 125 0", ok, n, c_ur);
    end
    push_c(16'hA5C3, 16'h1235);
    p = c_sclk; m = 0; first = -1; per = 0;
    while (m < 20) begin
      tick();
      m++;
      if (!p && c_sclk) begin
        if (first < 0) first = m;
        else begin
          per = m - first;
          break;
        end
      end
      p = c_sclk;
    end
    total++;
    if (per != 4) begin
      bad++; $display("FAIL small_sclk_period got=%0d want=4", per);
    end
    wait_fs(2, 200, ok, n, urs);
    total++;
    if (!ok || m + n != 128 || c_ur !== 1'b1) begin
      bad++; $display("FAIL small_frame ok=%0d cycles=%0d ur=%b want 1 128 1", ok, m + n, c_ur);
    end
    wait_fs(2, 200, ok, n, urs);
    total++;
    if (!ok) begin
      bad++; $display("FAIL small_drain got=%0d want=1", ok);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit found;
    logic p;
    n = 0;
    while (c_lrclk !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (c_lrclk !== 1'b1) begin
      bad++; $display("FAIL right_slot_reach got=%b want=1", c_lrclk);
    end
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({c_sclk, c_lrclk, c_dout, c_fs, c_ur, c_ready} !== 6'b000001) begin
      bad++; $display("FAIL midreset_outputs got=%b want=000001", {c_sclk, c_lrclk, c_dout, c_fs, c_ur, c_ready});
    end
    tick(); tick();
    rst_n = 1'b1;
    n = 0; found = 1'b0; p = c_sclk;
    while (n < 40) begin
      tick();
      n++;
      if (p && !c_sclk) begin
        found = 1'b1;
        break;
      end
      p = c_sclk;
    end
    total++;
    if (!found || n != 4) begin
      bad++; $display("FAIL first_fall_after_reset found=%0d cycles=%0d want 1 4", found, n);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_mute();
    test_small();
    test_reset_mid();
    total++;
    if (q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) begin
      bad++; $display("FAIL leftover_expect got=%0d/%0d/%0d want=0/0/0", q_a.size(), q_b.size(), q_c.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
